// File: rtl/ddr3_phy_pkg.sv
// Shared DDR3 PHY definitions: delay-sequencer command encodings and FSM state type.
package ddr3_phy_pkg;

  localparam logic [1:0] DLY_OP_WR     = 2'd0;
  localparam logic [1:0] DLY_OP_WR_ALL = 2'd1;
  localparam logic [1:0] DLY_OP_APPLY  = 2'd2;
  localparam logic [1:0] DLY_OP_RSVD   = 2'd3;

  localparam logic DLY_SEL_I = 1'b0;
  localparam logic DLY_SEL_O = 1'b1;

  typedef enum logic [1:0] {
    DLY_IDLE = 2'd0,
    DLY_SCAN = 2'd1,
    DLY_GAP  = 2'd2,
    DLY_LD   = 2'd3
  } dly_state_e;

endpackage

// File: rtl/dly_shadow_bank.sv
// Shadow tap registers and dirty flags for one delay set (IDELAY or ODELAY) of a lane.
module dly_shadow_bank
  import ddr3_phy_pkg::*;
#(
  parameter int NUM_BITS   = 9,
  parameter int DLY_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic                                wr_all,
  input  logic [ADDR_WIDTH-1:0]               wr_addr,
  input  logic [DLY_WIDTH-1:0]                wr_data,
  input  logic                                clr_en,
  input  logic [ADDR_WIDTH-1:0]               clr_idx,
  output logic [NUM_BITS-1:0][DLY_WIDTH-1:0]  shadow,
  output logic [NUM_BITS-1:0]                 dirty,
  output logic                                any_dirty
);

  logic [NUM_BITS-1:0][DLY_WIDTH-1:0] shadow_d, shadow_q;
  logic [NUM_BITS-1:0]                dirty_d, dirty_q;

  // Writes and scan clears never coincide: writes are only accepted while idle.
  always_comb begin
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (wr_all || (wr_en && (wr_addr == ADDR_WIDTH'(i)))) begin
        shadow_d[i] = wr_data;
        dirty_d[i]  = 1'b1;
      end else if (clr_en && (clr_idx == ADDR_WIDTH'(i))) begin
        dirty_d[i]  = 1'b0;
      end else begin
        dirty_d[i]  = dirty_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      dirty_q  <= {NUM_BITS{1'b0}};
    end else begin
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
    end
  end

  assign shadow    = shadow_q;
  assign dirty     = dirty_q;
  assign any_dirty = |dirty_q;

endmodule

// File: rtl/dq_lane_dly_seq.sv
// Per-lane IDELAY/ODELAY load sequencer: serialises dirty shadow taps onto dly_data, then loads all bits.
// Optional shadow readback port enabled by DQ_LANE_DLY_READBACK_EN.
module dq_lane_dly_seq
  import ddr3_phy_pkg::*;
#(
  parameter int NUM_BITS   = 9,
  parameter int DLY_WIDTH  = 8,
  parameter int SET_LD_GAP = 2,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic                  cmd_sel,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DLY_WIDTH-1:0]  cmd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DLY_WIDTH-1:0]  dly_data,
  output logic [NUM_BITS-1:0]   set_idelay,
  output logic [NUM_BITS-1:0]   set_odelay,
  output logic [NUM_BITS-1:0]   ld_idelay,
  output logic [NUM_BITS-1:0]   ld_odelay
`ifdef DQ_LANE_DLY_READBACK_EN
  ,
  input  logic                  rd_sel,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DLY_WIDTH-1:0]  rd_data,
  output logic                  rd_dirty
`endif
);

  localparam logic [ADDR_WIDTH:0]   NB_EXT   = NUM_BITS[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_BITS - 1);
  localparam logic [2:0]            GAP_LEN  = SET_LD_GAP[2:0];
  localparam logic [NUM_BITS-1:0]   ONE_BIT  = NUM_BITS'(1'b1);

  logic [NUM_BITS-1:0][DLY_WIDTH-1:0] shadow_i, shadow_o;
  logic [NUM_BITS-1:0]                dirty_i, dirty_o, bank_dirty;
  logic [DLY_WIDTH-1:0]               bank_tap;
  logic any_i, any_o;

  logic accept, addr_ok, wr_one, wr_every, start;
  logic scan_go, set_hit, ld_go;
  logic [ADDR_WIDTH-1:0] scan_idx;

  dly_state_e            state_d, state_q;
  logic [ADDR_WIDTH-1:0] idx_d, idx_q;
  logic [2:0]            gap_d, gap_q;
  logic                  sel_d, sel_q, any_d, any_q;
  logic                  busy_d, busy_q, cmd_ready_d, cmd_ready_q;
  logic                  done_d, done_q, err_d, err_q;
  logic [DLY_WIDTH-1:0]  dly_data_d, dly_data_q;
  logic [NUM_BITS-1:0]   set_i_d, set_i_q, set_o_d, set_o_q;
  logic [NUM_BITS-1:0]   ld_i_d, ld_i_q, ld_o_d, ld_o_q;

  assign accept   = cmd_valid && cmd_ready_q;
  assign addr_ok  = ({1'b0, cmd_addr} < NB_EXT);
  assign wr_one   = accept && (cmd_op == DLY_OP_WR) && addr_ok;
  assign wr_every = accept && (cmd_op == DLY_OP_WR_ALL);
  assign start    = accept && (cmd_op == DLY_OP_APPLY);

  dly_shadow_bank #(.NUM_BITS(NUM_BITS), .DLY_WIDTH(DLY_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank_i (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_one && (cmd_sel == DLY_SEL_I)),
    .wr_all    (wr_every && (cmd_sel == DLY_SEL_I)),
    .wr_addr   (cmd_addr),
    .wr_data   (cmd_data),
    .clr_en    (set_hit && (sel_d == DLY_SEL_I)),
    .clr_idx   (scan_idx),
    .shadow    (shadow_i),
    .dirty     (dirty_i),
    .any_dirty (any_i)
  );

  dly_shadow_bank #(.NUM_BITS(NUM_BITS), .DLY_WIDTH(DLY_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank_o (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_one && (cmd_sel == DLY_SEL_O)),
    .wr_all    (wr_every && (cmd_sel == DLY_SEL_O)),
    .wr_addr   (cmd_addr),
    .wr_data   (cmd_data),
    .clr_en    (set_hit && (sel_d == DLY_SEL_O)),
    .clr_idx   (scan_idx),
    .shadow    (shadow_o),
    .dirty     (dirty_o),
    .any_dirty (any_o)
  );

  // Outputs are registered from the next state, so cycle k of an apply shows the action of slot k.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    sel_d    = sel_q;
    any_d    = any_q;
    busy_d   = busy_q;
    scan_go  = 1'b0;
    scan_idx = idx_q;
    ld_go    = 1'b0;
    case (state_q)
      DLY_IDLE: begin
        if (start) begin
          state_d  = DLY_SCAN;
          idx_d    = {ADDR_WIDTH{1'b0}};
          sel_d    = cmd_sel;
          any_d    = (cmd_sel == DLY_SEL_O) ? any_o : any_i;
          busy_d   = 1'b1;
          scan_go  = 1'b1;
          scan_idx = {ADDR_WIDTH{1'b0}};
        end else begin
          state_d  = DLY_IDLE;
        end
      end
      DLY_SCAN: begin
        if (idx_q != LAST_IDX) begin
          idx_d    = idx_q + ADDR_WIDTH'(1);
          scan_go  = 1'b1;
          scan_idx = idx_q + ADDR_WIDTH'(1);
        end else if (GAP_LEN != 3'd0) begin
          state_d  = DLY_GAP;
          gap_d    = 3'd1;
        end else begin
          state_d  = DLY_LD;
          ld_go    = 1'b1;
        end
      end
      DLY_GAP: begin
        if (gap_q == GAP_LEN) begin
          state_d  = DLY_LD;
          ld_go    = 1'b1;
        end else begin
          gap_d    = gap_q + 3'd1;
        end
      end
      DLY_LD: begin
        state_d = DLY_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = DLY_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bank_dirty = (sel_d == DLY_SEL_O) ? dirty_o : dirty_i;
  assign bank_tap   = (sel_d == DLY_SEL_O) ? shadow_o[scan_idx] : shadow_i[scan_idx];
  assign set_hit    = scan_go && bank_dirty[scan_idx];

  // Strobe and data bus next values.
  always_comb begin
    cmd_ready_d = !busy_d;
    done_d      = ld_go;
    err_d       = accept && ((cmd_op == DLY_OP_RSVD) || ((cmd_op == DLY_OP_WR) && !addr_ok));
    if (set_hit) begin
      dly_data_d = bank_tap;
      set_i_d    = (sel_d == DLY_SEL_I) ? (ONE_BIT << scan_idx) : {NUM_BITS{1'b0}};
      set_o_d    = (sel_d == DLY_SEL_O) ? (ONE_BIT << scan_idx) : {NUM_BITS{1'b0}};
    end else begin
      dly_data_d = dly_data_q;
      set_i_d    = {NUM_BITS{1'b0}};
      set_o_d    = {NUM_BITS{1'b0}};
    end
    if (ld_go && any_q) begin
      ld_i_d = (sel_q == DLY_SEL_I) ? {NUM_BITS{1'b1}} : {NUM_BITS{1'b0}};
      ld_o_d = (sel_q == DLY_SEL_O) ? {NUM_BITS{1'b1}} : {NUM_BITS{1'b0}};
    end else begin
      ld_i_d = {NUM_BITS{1'b0}};
      ld_o_d = {NUM_BITS{1'b0}};
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DLY_IDLE;
      idx_q       <= {ADDR_WIDTH{1'b0}};
      gap_q       <= 3'd0;
      sel_q       <= DLY_SEL_I;
      any_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dly_data_q  <= {DLY_WIDTH{1'b0}};
      set_i_q     <= {NUM_BITS{1'b0}};
      set_o_q     <= {NUM_BITS{1'b0}};
      ld_i_q      <= {NUM_BITS{1'b0}};
      ld_o_q      <= {NUM_BITS{1'b0}};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      sel_q       <= sel_d;
      any_q       <= any_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      dly_data_q  <= dly_data_d;
      set_i_q     <= set_i_d;
      set_o_q     <= set_o_d;
      ld_i_q      <= ld_i_d;
      ld_o_q      <= ld_o_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dly_data   = dly_data_q;
  assign set_idelay = set_i_q;
  assign set_odelay = set_o_q;
  assign ld_idelay  = ld_i_q;
  assign ld_odelay  = ld_o_q;

`ifdef DQ_LANE_DLY_READBACK_EN
  always_comb begin
    if ({1'b0, rd_addr} < NB_EXT) begin
      rd_data  = (rd_sel == DLY_SEL_O) ? shadow_o[rd_addr] : shadow_i[rd_addr];
      rd_dirty = (rd_sel == DLY_SEL_O) ? dirty_o[rd_addr] : dirty_i[rd_addr];
    end else begin
      rd_data  = {DLY_WIDTH{1'b0}};
      rd_dirty = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dq_lane_dly_seq.sv
// Randomized bench for dq_lane_dly_seq against a cycle-timeline reference model of the lane shadows.
module tb_dq_lane_dly_seq;
  localparam int N  = 9;
  localparam int G  = 2;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int T_LD = N + G + 1;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_sel, busy, done, err;
  logic [1:0] cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data, dly_data;
  logic [N-1:0] set_idelay, set_odelay, ld_idelay, ld_odelay;
`ifdef DQ_LANE_DLY_READBACK_EN
  logic rd_sel;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic rd_dirty;
  assign rd_sel  = 1'b0;
  assign rd_addr = 4'd0;
`endif

  dq_lane_dly_seq #(.NUM_BITS(N), .DLY_WIDTH(DW), .SET_LD_GAP(G), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy), .done(done),
    .err(err), .dly_data(dly_data), .set_idelay(set_idelay), .set_odelay(set_odelay),
    .ld_idelay(ld_idelay), .ld_odelay(ld_odelay)
`ifdef DQ_LANE_DLY_READBACK_EN
    , .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data), .rd_dirty(rd_dirty)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: shadow taps, dirty flags, and the last value put on dly_data.
  logic [DW-1:0] sh [2][N];
  bit            dr [2][N];
  logic [DW-1:0] exp_dly;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < N; i++) begin
        sh[s][i] = 8'h00;
        dr[s][i] = 1'b0;
      end
    exp_dly = 8'h00;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_dly"}, dly_data, exp_dly);
    chk({tag, "_strobes"}, {set_idelay, set_odelay, ld_idelay, ld_odelay}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    @(negedge clk);
    check_idle("rst");
    chk("rst_err", err, 0);
  endtask

  // Presents one command, waits (bounded) for cmd_ready, returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic sel, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_addr = addr; cmd_data = data;
    for (int t = 0; t < 40 && !cmd_ready; t++) @(negedge clk);
    if (!cmd_ready) chk("ready_wait", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] op, input logic sel, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit bad;
    bad = (op == 2'd3) || (op == 2'd0 && addr >= N);
    send(op, sel, addr, data);
    if (op == 2'd0 && !bad) begin
      sh[sel][addr] = data;
      dr[sel][addr] = 1'b1;
    end else if (op == 2'd1) begin
      for (int i = 0; i < N; i++) begin
        sh[sel][i] = data;
        dr[sel][i] = 1'b1;
      end
    end
    @(negedge clk);
    chk("wr_err", err, bad);
    check_idle("wr");
    @(negedge clk);
    chk("err_pulse_end", err, 0);
  endtask

  // Apply of one set; abort_at > 0 resets the DUT during that cycle of the apply.
  task automatic do_apply(input logic sel, input int abort_at);
    logic [N-1:0] es;
    bit any;
    any = 1'b0;
    for (int i = 0; i < N; i++) any |= dr[sel][i];
    send(2'd2, sel, 4'd0, 8'h00);
    for (int k = 1; k <= T_LD + 1; k++) begin
      @(negedge clk);
      es = '0;
      if (k <= N && dr[sel][k-1]) begin
        es[k-1] = 1'b1;
        exp_dly = sh[sel][k-1];
        dr[sel][k-1] = 1'b0;
      end
      chk("ap_busy", busy, k <= T_LD);
      chk("ap_ready", cmd_ready, k == T_LD + 1);
      chk("ap_set_i", set_idelay, sel ? 9'h000 : es);
      chk("ap_set_o", set_odelay, sel ? es : 9'h000);
      chk("ap_dly", dly_data, exp_dly);
      chk("ap_ld_i", ld_idelay, (k == T_LD && any && !sel) ? 9'h1FF : 9'h000);
      chk("ap_ld_o", ld_odelay, (k == T_LD && any && sel) ? 9'h1FF : 9'h000);
      chk("ap_done", done, k == T_LD);
      chk("ap_err", err, 0);
      if (k == abort_at) break;
    end
  endtask

  task automatic quiet_after_abort();
    for (int k = 0; k < T_LD + 2; k++) begin
      @(negedge clk);
      check_idle("abort");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] op;
    logic sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int r;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_sel = 1'b0; cmd_addr = 4'd0; cmd_data = 8'h00;
    @(negedge clk);
    do_reset();
    do_apply(1'b0, 0);

    do_write(2'd0, 1'b0, 4'd3, 8'h2A);
    do_apply(1'b0, 0);

    do_write(2'd1, 1'b1, 4'd0, 8'h55);
    do_apply(1'b1, 0);
    do_apply(1'b1, 0);

    do_write(2'd0, 1'b0, 4'd12, 8'hFF);
    do_write(2'd3, 1'b1, 4'd0, 8'h77);
    do_write(2'd0, 1'b1, 4'd8, 8'hC3);
    do_apply(1'b0, 0);
    do_apply(1'b1, 0);

    do_write(2'd1, 1'b0, 4'd0, 8'h9E);
    do_apply(1'b0, 5);
    @(negedge clk);
    do_reset();
    quiet_after_abort();
    do_apply(1'b0, 0);
    do_apply(1'b1, 0);

    for (int it = 0; it < 60; it++) begin
      r    = $urandom_range(0, 9);
      sel  = 1'($urandom_range(0, 1));
      addr = 4'($urandom_range(0, 15));
      data = 8'($urandom);
      if (r < 5) op = 2'd0;
      else if (r < 6) op = 2'd1;
      else if (r < 9) op = 2'd2;
      else op = 2'd3;
      if (op == 2'd2) do_apply(sel, 0);
      else do_write(op, sel, addr, data);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
